boot_sequencer: RTL and testbench

//  Reset/boot front end for the MSP430 pipeline. It produces the pipeline's reset inputs:
//   - pipe_rst (active-high)
//   - RST_VEC
//   - reg_SP_in
//   - reg_SR_in

---
 rtl/boot_sequencer_if.sv | 26 ++
 rtl/boot_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_boot_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_sequencer_if.sv
// Memory read port used by the boot sequencer to fetch the reset vector.
//   mem_addr  : read address (sequencer -> memory)
//   mem_rd    : read request, held until acknowledged or abandoned
//   mem_rdata : read data, meaningful only while mem_ack is high
//   mem_ack   : read acknowledge; may coincide with the first mem_rd cycle
// master = sequencer side, slave = memory side.
interface boot_sequencer_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/boot_sequencer.sv
// Reset/boot front end for the MSP430 pipeline.
// Holds the pipeline in reset, fetches the reset vector over a req/ack read,
// validates it (falls back to DEFAULT_VEC on a bad or missing vector) and then
// releases the pipeline. A software/watchdog request in RUN restarts the sequence.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous reset, active low
//   sw_rst_req : restart request pulse, honoured only in RUN
//   mem        : vector read port (boot_sequencer_if.master)
//   pipe_rst   : active-high reset to the pipeline
//   RST_VEC    : reset vector handed to the pipeline
//   reg_SP_in  : initial stack pointer (SP_INIT)
//   reg_SR_in  : initial status register (SR_INIT)
//   boot_done  : high while in RUN
//   boot_fault : DEFAULT_VEC was substituted in this sequence
module boot_sequencer #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned MAX_RETRY   = 2,
  parameter logic [15:0] VEC_ADDR    = 16'hFFFE,
  parameter logic [15:0] DEFAULT_VEC = 16'hC000,
  parameter logic [15:0] SP_INIT     = 16'h0400,
  parameter logic [15:0] SR_INIT     = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_rst_req,
  boot_sequencer_if.master       mem,
  output logic                   pipe_rst,
  output logic [15:0]            RST_VEC,
  output logic [15:0]            reg_SP_in,
  output logic [15:0]            reg_SR_in,
  output logic                   boot_done,
  output logic                   boot_fault
);

  localparam int unsigned HOLD_W  = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam int unsigned TO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_REQ,
    S_WAIT,
    S_CHECK,
    S_RUN
  } state_e;

  state_e               state_q, state_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [15:0]          data_q, data_d;
  logic                 pipe_rst_q, pipe_rst_d;
  logic                 mem_rd_q, mem_rd_d;
  logic [15:0]          rst_vec_q, rst_vec_d;
  logic                 done_q, done_d;
  logic                 fault_q, fault_d;
  logic [15:0]          mem_addr_q;
  logic [15:0]          sp_q;
  logic [15:0]          sr_q;
  logic                 vec_bad;

  // Odd vectors cannot be fetched; all-zeros / all-ones means erased flash.
  assign vec_bad = data_q[0] || (data_q == '0) || (data_q == '1);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    to_cnt_d   = to_cnt_q;
    retry_d    = retry_q;
    data_d     = data_q;
    pipe_rst_d = pipe_rst_q;
    mem_rd_d   = mem_rd_q;
    rst_vec_d  = rst_vec_q;
    done_d     = done_q;
    fault_d    = fault_q;

    unique case (state_q)
      S_HOLD: begin
        pipe_rst_d = 1'b1;
        if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          hold_cnt_d = '0;
          state_d    = S_REQ;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      S_REQ: begin
        mem_rd_d = 1'b1;
        to_cnt_d = '0;
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        // Ack is tested first so an ack in the timeout cycle still wins.
        if (mem.mem_ack) begin
          data_d   = mem.mem_rdata;
          mem_rd_d = 1'b0;
          state_d  = S_CHECK;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          mem_rd_d = 1'b0;
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = S_REQ;
          end else begin
            fault_d    = 1'b1;
            rst_vec_d  = DEFAULT_VEC;
            pipe_rst_d = 1'b0;
            done_d     = 1'b1;
            state_d    = S_RUN;
          end
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_CHECK: begin
        if (vec_bad) begin
          rst_vec_d = DEFAULT_VEC;
          fault_d   = 1'b1;
        end else begin
          rst_vec_d = data_q;
        end
        pipe_rst_d = 1'b0;
        done_d     = 1'b1;
        state_d    = S_RUN;
      end

      S_RUN: begin
        // RST_VEC is deliberately left alone so it stays valid until the
        // next CHECK or fault overwrites it.
        if (sw_rst_req) begin
          pipe_rst_d = 1'b1;
          done_d     = 1'b0;
          fault_d    = 1'b0;
          hold_cnt_d = '0;
          to_cnt_d   = '0;
          retry_d    = '0;
          state_d    = S_HOLD;
        end
      end

      default: begin
        state_d = S_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    mem_addr_q <= VEC_ADDR;
    sp_q       <= SP_INIT;
    sr_q       <= SR_INIT;
    if (!rst) begin
      state_q    <= S_HOLD;
      hold_cnt_q <= '0;
      to_cnt_q   <= '0;
      retry_q    <= '0;
      data_q     <= '0;
      pipe_rst_q <= 1'b1;
      mem_rd_q   <= 1'b0;
      rst_vec_q  <= DEFAULT_VEC;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      to_cnt_q   <= to_cnt_d;
      retry_q    <= retry_d;
      data_q     <= data_d;
      pipe_rst_q <= pipe_rst_d;
      mem_rd_q   <= mem_rd_d;
      rst_vec_q  <= rst_vec_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
    end
  end

  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_rd   = mem_rd_q;
  assign pipe_rst     = pipe_rst_q;
  assign RST_VEC      = rst_vec_q;
  assign reg_SP_in    = sp_q;
  assign reg_SR_in    = sr_q;
  assign boot_done    = done_q;
  assign boot_fault   = fault_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Testbench for boot_sequencer: a memory responder replays a per-run ack plan,
// a reference model predicts release edge, vector, fault flag and read-pulse
// lengths, and a monitor pops those predictions as the DUT produces them.
module tb_boot_sequencer;
  localparam int          HOLD = 4;
  localparam int          TO   = 16;
  localparam int          MR   = 2;
  localparam logic [15:0] DEF  = 16'hC000;
  localparam logic [15:0] ADDR = 16'hFFFE;
  localparam logic [15:0] SP   = 16'h0400;
  localparam logic [15:0] SR   = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sw_rst_req = 1'b0;
  logic        pipe_rst;
  logic [15:0] RST_VEC, reg_SP_in, reg_SR_in;
  logic        boot_done, boot_fault;

  boot_sequencer_if bif();

  boot_sequencer #(
    .HOLD_CYCLES(HOLD),
    .TIMEOUT    (TO),
    .MAX_RETRY  (MR),
    .VEC_ADDR   (ADDR),
    .DEFAULT_VEC(DEF),
    .SP_INIT    (SP),
    .SR_INIT    (SR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_rst_req(sw_rst_req),
    .mem       (bif),
    .pipe_rst  (pipe_rst),
    .RST_VEC   (RST_VEC),
    .reg_SP_in (reg_SP_in),
    .reg_SR_in (reg_SR_in),
    .boot_done (boot_done),
    .boot_fault(boot_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] vec;
    logic        fault;
    int          fall_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   pulse_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   need_reset = 0;

  // Per-run memory behaviour: ack delay per attempt (-1 = never ack).
  int          plan_dly[3];
  logic [15:0] plan_data;
  int          att = 0;
  int          hi_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory responder
  logic resp_prev_rd = 1'b0;
  initial begin
    bif.mem_ack   = 1'b0;
    bif.mem_rdata = 16'h0;
  end
  always @(posedge clk) begin
    #1;
    if (bif.mem_rd === 1'b1) begin
      if (att < 3 && hi_cnt == plan_dly[att]) begin
        bif.mem_ack   = 1'b1;
        bif.mem_rdata = plan_data;
      end else begin
        bif.mem_ack   = 1'b0;
        bif.mem_rdata = 16'($urandom);
      end
      hi_cnt++;
    end else begin
      if (resp_prev_rd) att++;
      hi_cnt = 0;
      // Stray acks while no read is pending must be ignored by the DUT.
      bif.mem_ack   = ($urandom_range(3) == 0);
      bif.mem_rdata = 16'($urandom);
    end
    resp_prev_rd = (bif.mem_rd === 1'b1);
  end

  // Monitor / scoreboard
  logic        mon_prev_pipe = 1'b1;
  logic        mon_prev_rd = 1'b0;
  int          rd_len = 0;
  logic [15:0] cur_vec = DEF;
  always @(posedge clk) begin
    exp_t e;
    int   plen;
    #1;
    if (mon_prev_pipe === 1'b1 && pipe_rst === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_release: got release at cycle %0d expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("release_edge", cyc, e.fall_cyc);
        chk("rst_vec", RST_VEC, e.vec);
        chk("boot_fault", boot_fault, e.fault);
        chk("boot_done", boot_done, 1);
        chk("reg_SP_in", reg_SP_in, SP);
        chk("reg_SR_in", reg_SR_in, SR);
        cur_vec = e.vec;
      end
    end else if (mon_prev_pipe === 1'b0 && pipe_rst === 1'b0) begin
      chk("vec_stable", RST_VEC, cur_vec);
    end

    if (bif.mem_rd === 1'b1) begin
      rd_len++;
      if (rd_len == 1) chk("mem_addr", bif.mem_addr, ADDR);
    end else if (mon_prev_rd) begin
      if (pulse_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read: got pulse of %0d expected none", rd_len);
      end else begin
        plen = pulse_q.pop_front();
        chk("rd_pulse_len", rd_len, plen);
      end
      rd_len = 0;
    end
    mon_prev_pipe = pipe_rst;
    mon_prev_rd   = (bif.mem_rd === 1'b1);
  end

  task automatic plan(input int d0, input int d1, input int d2, input logic [15:0] data);
    plan_dly[0] = d0;
    plan_dly[1] = d1;
    plan_dly[2] = d2;
    plan_data   = data;
  endtask

  // Reference model: each timed-out request costs one REQ cycle plus TO
  // wait cycles; an acked request costs REQ + (delay+1) wait cycles + CHECK.
  task automatic launch(input bit by_reset, input bit noise);
    int          lat;
    int          base;
    exp_t        e;
    logic [15:0] prev_vec;
    bit          got;
    lat     = HOLD;
    got     = 0;
    e.vec   = DEF;
    e.fault = 1'b1;
    for (int a = 0; a <= MR; a++) begin
      if (!got) begin
        if (plan_dly[a] >= 0 && plan_dly[a] < TO) begin
          pulse_q.push_back(plan_dly[a] + 1);
          lat += plan_dly[a] + 3;
          e.fault = plan_data[0] || plan_data == 16'h0000 || plan_data == 16'hFFFF;
          e.vec   = e.fault ? DEF : plan_data;
          got     = 1;
        end else begin
          pulse_q.push_back(TO);
          lat += 1 + TO;
        end
      end
    end

    @(negedge clk);
    att    = 0;
    hi_cnt = 0;
    if (by_reset || need_reset) begin
      need_reset = 0;
      rst = 1'b0;
      @(negedge clk);
      rst  = 1'b1;
      base = cyc;
      e.fall_cyc = base + lat;
      exp_q.push_back(e);
    end else begin
      prev_vec   = RST_VEC;
      sw_rst_req = 1'b1;
      base       = cyc + 1;
      e.fall_cyc = base + lat;
      exp_q.push_back(e);
      @(negedge clk);
      sw_rst_req = 1'b0;
      chk("sw_pipe_rst", pipe_rst, 1);
      chk("sw_boot_done", boot_done, 0);
      chk("sw_boot_fault", boot_fault, 0);
      chk("sw_vec_kept", RST_VEC, prev_vec);
    end

    if (noise) begin
      @(negedge clk);
      sw_rst_req = 1'b1;
      @(negedge clk);
      sw_rst_req = 1'b0;
    end

    for (int i = 0; i < lat + 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL release_timeout: got no release expected at cycle %0d", base + lat);
      exp_q.delete();
      pulse_q.delete();
      need_reset = 1;
    end else begin
      chk("pulses_left", pulse_q.size(), 0);
      pulse_q.delete();
    end
    repeat ($urandom_range(6, 1)) @(negedge clk);
  endtask

  task automatic abort_test();
    bit seen;
    plan(-1, -1, -1, 16'h1234);
    pulse_q.push_back(1);
    @(negedge clk);
    att    = 0;
    hi_cnt = 0;
    rst    = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bif.mem_rd === 1'b1) seen = 1;
    end
    chk("abort_rd_seen", seen, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_mem_rd", bif.mem_rd, 0);
    chk("abort_pipe_rst", pipe_rst, 1);
    chk("abort_boot_done", boot_done, 0);
    chk("abort_pulses_left", pulse_q.size(), 0);
    pulse_q.delete();
  endtask

  initial begin
    int          r;
    logic [15:0] d;
    int          dl[3];
    rst = 1'b0;
    plan(-1, -1, -1, 16'h0);
    repeat (3) @(negedge clk);
    chk("reset_pipe_rst", pipe_rst, 1);
    chk("reset_mem_rd", bif.mem_rd, 0);
    chk("reset_rst_vec", RST_VEC, DEF);
    chk("reset_sp", reg_SP_in, SP);
    chk("reset_sr", reg_SR_in, SR);
    chk("reset_boot_done", boot_done, 0);
    chk("reset_boot_fault", boot_fault, 0);

    plan(0, -1, -1, 16'hC010);  launch(1, 0);
    plan(5, -1, -1, 16'hE000);  launch(0, 0);
    plan(0, -1, -1, 16'hC001);  launch(0, 0);
    plan(0, -1, -1, 16'hFFFF);  launch(0, 0);
    plan(0, -1, -1, 16'h0000);  launch(0, 0);
    plan(-1, -1, -1, 16'h1234); launch(0, 0);
    plan(-1, 0, -1, 16'hD000);  launch(0, 0);
    plan(15, -1, -1, 16'hA000); launch(0, 1);
    plan(16, 3, -1, 16'hB002);  launch(0, 0);
    plan(0, -1, -1, 16'hC100);  launch(0, 0);
    abort_test();
    plan(2, -1, -1, 16'hC200);  launch(1, 0);

    for (int n = 0; n < 14; n++) begin
      for (int a = 0; a < 3; a++) begin
        r = $urandom_range(9);
        if (r < 3)       dl[a] = -1;
        else if (r == 3) dl[a] = TO - 1;
        else if (r == 4) dl[a] = TO;
        else             dl[a] = $urandom_range(TO - 2);
      end
      r = $urandom_range(7);
      d = 16'($urandom);
      if (r == 0)      d = 16'h0000;
      else if (r == 1) d = 16'hFFFF;
      else if (r == 2) d = d | 16'h0001;
      else             d = d & 16'hFFFE;
      plan(dl[0], dl[1], dl[2], d);
      launch($urandom_range(3) == 0, $urandom_range(2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
